hex_display_arbiter: RTL and testbench
======================================

// Module: hex_display_arbiter
// PURPOSE
//   Shares the six-digit HEX display between NUM_REQ requesters via round-robin arbitration with a minimum dwell time.
//   Outputs the granted requester's six nibbles plus a per-digit blank mask.
//   Downstream, six seg7 decoder instances drive HEX0..HEX5; blank[i] forces HEXi to 7'h7F.
// PARAMETERS
//   NUM_REQ      4           number of requesters (>=2)
//   HOLD_CYCLES  50_000_000  minimum cycles an owner keeps the display before preemption (>=1; 1 s at 50 MHz)
// PORTS
//   clk     in   1            system clock; all state on posedge clk
//   reset   in   1            asynchronous, active-high reset
//   req     in   NUM_REQ      per-requester display request, level-held
//   value   in   NUM_REQ*24   requester r's digits at value[r*24 +: 24]; nibble i -> HEXi
//   grant   out  NUM_REQ      one-hot current owner; all-zero when idle
//   digits  out  24           owner's nibbles, registered
//   blank   out  6            1 = digit i dark
//   valid   out  1            1 while any requester owns the display
// BEHAVIOUR
//   Reset values (async): state=IDLE, grant=0, digits=0, blank=6'h3F, valid=0, rr_ptr=0, dwell=0.
//   State machine, registered outputs:
//   - IDLE: if req!=0, pick the first requester at or after rr_ptr (wrapping) and go to HOLD.
//     grant/valid assert the cycle after req is sampled. dwell=0.
//   - HOLD: dwell increments each cycle.
//     - At dwell==HOLD_CYCLES-1 with owner still requesting -> OPEN.
//     - Other requests are ignored in HOLD; the dwell is a preemption floor only.
//     - Owner drops req: release immediately; go to the next requester after the owner if any, else IDLE.
//   - OPEN: owner keeps the display while req[owner]=1 and no other req is set.
//     - Another req appears, or the owner drops req: switch to the next requesting index after the owner (wrapping), enter HOLD, dwell=0.
//     - If none remain -> IDLE.
//   Switch/release rules:
//   - A switch changes grant old->new in one cycle, with no idle gap.
//   - After every switch or release, rr_ptr = old owner+1 (mod NUM_REQ).
//   - Owner drops req on the same cycle dwell expires: treated as release.
//   - All req drop: IDLE next cycle, grant=0, valid=0, blank=6'h3F, digits hold their last value.
//   Data path:
//   - While valid, digits <= value[owner*24 +: 24] every cycle: one-cycle latency, live tracking.
//   - On a switch, digits load the new owner's value in the same cycle grant changes.
//   Counter: dwell width $clog2(HOLD_CYCLES+1), saturates, never wraps. HOLD_CYCLES=1 means HOLD lasts exactly one cycle.
//   Reset mid-operation: all outputs return to reset values asynchronously; arbitration restarts from index 0.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN
//   - Defined: while valid, blank[i]=1 for every digit above the most significant non-zero nibble. blank[0] is never set, so 000000 shows "0".
//   - Undefined: blank=6'h00 while valid.
//   - Either way: blank=6'h3F when not valid.
// STRUCTURE
//   Package hex_disp_pkg:
//   - DIGITS=6 and NIBBLE_W=4.
//   - typedef enum logic [1:0] {IDLE, HOLD, OPEN} arb_state_t.
//   - function lz_mask(24-bit) -> 6-bit blank mask.
//   Sub-module rr_picker: combinational; inputs req and start index; outputs found and the index of the first set bit at/after start.
//   Instantiated once, reused for both the IDLE pick and the switch pick.
// TESTING (bench: NUM_REQ=4, HOLD_CYCLES=4)
//   1. Reset with req=4'b0000 -> grant=0, valid=0, blank=6'h3F, digits=0. Assert reset mid-HOLD -> same values immediately, before the next clk edge.
//   2. req=4'b0100, value[2]=24'h123456 -> next cycle grant=4'b0100, digits=24'h123456, valid=1. Change value[2] to 24'hABCDEF -> digits follow one cycle later.
//   3. Owner 2 in HOLD; raise req[0] at dwell=1 -> grant stays 4'b0100 through dwell=3, then becomes 4'b0001 exactly when 0 is chosen from OPEN.
//   4. req=4'b1111 held -> owners cycle 0,1,2,3,0. Each holds exactly HOLD_CYCLES cycles in HOLD plus 1 cycle in OPEN; grant is never zero.
//   5. Owner 1 drops req at dwell=2 with req[3]=1 -> grant=4'b1000 next cycle. Then drop all req -> IDLE, blank=6'h3F, digits unchanged.
//   6. With LEADING_ZERO_BLANK_EN: 24'h000120 -> blank=6'b111000; 24'h000000 -> blank=6'b111110. Without the macro, both give blank=6'b000000.

Source files
------------

// File: rtl/hex_display_arbiter_pkg.sv
// hex_disp_pkg: shared constants, arbiter state type and leading-zero blank helper
package hex_disp_pkg;
    localparam int DIGITS   = 6;
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {IDLE, HOLD, OPEN} arb_state_t;

    // Dark every digit above the most significant non-zero nibble; digit 0 always lit
    function automatic logic [DIGITS-1:0] lz_mask(input logic [DIGITS*NIBBLE_W-1:0] v);
        logic z;
        lz_mask = '0;
        z       = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            z          = z & (v[i*NIBBLE_W +: NIBBLE_W] == '0);
            lz_mask[i] = z;
        end
    endfunction
endpackage

// File: rtl/hex_display_arbiter_if.sv
// hex_display_arbiter_if: requester-side request/value bus and display-side grant/digit outputs
interface hex_display_arbiter_if #(parameter int NUM_REQ = 4);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*24-1:0] value;
    logic [NUM_REQ-1:0]    grant;
    logic [23:0]           digits;
    logic [5:0]            blank;
    logic                  valid;

    modport master (output req, value, input grant, digits, blank, valid);
    modport slave  (input req, value, output grant, digits, blank, valid);
endinterface

// File: rtl/hex_display_arbiter_rr_picker.sv
// rr_picker: first set request bit at or after a start index, wrapping around
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);
    // Scan from farthest to nearest so the nearest set bit wins
    always_comb begin
        found = 1'b0;
        idx   = start;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(start) + k) % N]) begin
                found = 1'b1;
                idx   = IW'((int'(start) + k) % N);
            end
        end
    end
endmodule

// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: round-robin HEX display sharing with minimum dwell; optional LEADING_ZERO_BLANK_EN
module hex_display_arbiter
    import hex_disp_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input logic                  clk,
    input logic                  reset,
    hex_display_arbiter_if.slave bus
);
    localparam int IW  = $clog2(NUM_REQ);
    localparam int DWW = $clog2(HOLD_CYCLES + 1);
    localparam int VW  = DIGITS * NIBBLE_W;

    arb_state_t          state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d, rr_ptr_q, rr_ptr_d, nxt_owner, start, pick;
    logic [DWW-1:0]      dwell_q, dwell_d, dwell_inc;
    logic [NUM_REQ-1:0]  grant_q, grant_d, owner_bit;
    logic [VW-1:0]       digits_q, digits_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic                valid_q, valid_d, found, owner_req, others, leave;

    assign nxt_owner = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign start     = (state_q == IDLE) ? rr_ptr_q : nxt_owner;
    assign owner_bit = NUM_REQ'(1) << owner_q;
    assign owner_req = |(bus.req & owner_bit);
    assign others    = |(bus.req & ~owner_bit);
    assign leave     = (state_q == HOLD && !owner_req) || (state_q == OPEN && (!owner_req || others));
    assign dwell_inc = (dwell_q == DWW'(HOLD_CYCLES)) ? dwell_q : dwell_q + 1'b1;

    rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req   (bus.req),
        .start (start),
        .found (found),
        .idx   (pick)
    );

    // Next owner/state: pick from IDLE or on switch/release, open the floor when dwell expires
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        dwell_d  = (state_q == IDLE) ? '0 : dwell_inc;
        if (state_q == IDLE || leave) begin
            state_d  = found ? HOLD : IDLE;
            owner_d  = found ? pick : owner_q;
            dwell_d  = '0;
            rr_ptr_d = leave ? nxt_owner : rr_ptr_q;
        end else if (state_q == HOLD && dwell_q == DWW'(HOLD_CYCLES - 1)) begin
            state_d = OPEN;
        end
        valid_d  = state_d != IDLE;
        grant_d  = valid_d ? NUM_REQ'(1) << owner_d : '0;
        digits_d = valid_d ? bus.value[int'(owner_d)*VW +: VW] : digits_q;
`ifdef LEADING_ZERO_BLANK_EN
        blank_d  = valid_d ? lz_mask(digits_d) : '1;
`else
        blank_d  = valid_d ? '0 : '1;
`endif
    end

    // Arbiter state and registered display outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            dwell_q  <= '0;
            grant_q  <= '0;
            digits_q <= '0;
            blank_q  <= '1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            dwell_q  <= dwell_d;
            grant_q  <= grant_d;
            digits_q <= digits_d;
            blank_q  <= blank_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.grant  = grant_q;
    assign bus.digits = digits_q;
    assign bus.blank  = blank_q;
    assign bus.valid  = valid_q;
endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb_hex_display_arbiter: directed and random checks against an owner/age reference model
module tb_hex_display_arbiter;
    localparam int N = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hex_display_arbiter_if #(.NUM_REQ(N)) bus ();
    hex_display_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(H)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk = 0;
    int n_err = 0;
    int m_own, m_age, m_rr;
    logic [23:0] m_dig;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int first_from(input int s, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) if (r[(s + k) % N]) return (s + k) % N;
        return -1;
    endfunction

    function automatic logic [5:0] exp_blank(input int own, input logic [23:0] d);
        logic [6:0] t;
        int msd;
        if (own < 0) return 6'h3F;
        msd = 0;
        for (int i = 0; i < 6; i++) if (d[i*4 +: 4] != 4'h0) msd = i;
        t = 7'h7F;
        t = t << (msd + 1);
`ifdef LEADING_ZERO_BLANK_EN
        return t[5:0];
`else
        return (t[5:0] & 6'h00);
`endif
    endfunction

    task automatic model_reset();
        m_own = -1; m_age = 0; m_rr = 0; m_dig = '0;
    endtask

    // Owner keeps display for at least H cycles; after that yields to any other requester
    task automatic model_step();
        logic [N-1:0] r;
        r = bus.req;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_own < 0) begin
            m_own = first_from(m_rr, r);
            m_age = 0;
        end else if (!r[m_own] || (m_age >= H && (r & ~(N'(1) << m_own)) != '0)) begin
            m_rr  = (m_own + 1) % N;
            m_own = first_from(m_rr, r);
            m_age = 0;
        end else begin
            m_age++;
        end
        if (m_own >= 0) m_dig = bus.value[m_own*24 +: 24];
    endtask

    task automatic compare_all();
        chk("grant", 32'(bus.grant), m_own < 0 ? 32'd0 : 32'd1 << m_own);
        chk("valid", 32'(bus.valid), 32'(m_own >= 0));
        chk("digits", 32'(bus.digits), 32'(m_dig));
        chk("blank", 32'(bus.blank), 32'(exp_blank(m_own, m_dig)));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic setv(input int r, input logic [23:0] v);
        bus.value[r*24 +: 24] = v;
    endtask

    initial begin
        reset     = 1'b1;
        bus.req   = '0;
        bus.value = '0;
        model_reset();
        repeat (2) cycle();
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_blank", 32'(bus.blank), 32'h3F);
        chk("rst_digits", 32'(bus.digits), 32'd0);
        reset = 1'b0;

        setv(2, 24'h123456);
        bus.req = 4'b0100;
        cycle();
        chk("t2_grant", 32'(bus.grant), 32'h4);
        chk("t2_digits", 32'(bus.digits), 32'h123456);
        chk("t2_valid", 32'(bus.valid), 32'd1);
        setv(2, 24'hABCDEF);
        cycle();
        chk("t2_track", 32'(bus.digits), 32'hABCDEF);

        bus.req = 4'b0101;
        repeat (3) begin
            cycle();
            chk("t3_hold", 32'(bus.grant), 32'h4);
        end
        cycle();
        chk("t3_switch", 32'(bus.grant), 32'h1);

        cycle();
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_grant", 32'(bus.grant), 32'd0);
        chk("async_valid", 32'(bus.valid), 32'd0);
        chk("async_blank", 32'(bus.blank), 32'h3F);
        chk("async_digits", 32'(bus.digits), 32'd0);
        cycle();
        reset = 1'b0;

        bus.req = 4'b1111;
        for (int k = 0; k < 25; k++) begin
            cycle();
            chk("t4_owner", 32'(bus.grant), 32'd1 << ((k / 5) % 4));
        end

        reset = 1'b1;
        cycle();
        reset = 1'b0;
        setv(3, 24'h0F0F0F);
        bus.req = 4'b1010;
        repeat (3) cycle();
        chk("t5_owner", 32'(bus.grant), 32'h2);
        bus.req = 4'b1000;
        cycle();
        chk("t5_switch", 32'(bus.grant), 32'h8);
        bus.req = 4'b0000;
        cycle();
        chk("t5_idle_grant", 32'(bus.grant), 32'd0);
        chk("t5_idle_valid", 32'(bus.valid), 32'd0);
        chk("t5_idle_blank", 32'(bus.blank), 32'h3F);
        chk("t5_idle_digits", 32'(bus.digits), 32'h0F0F0F);

        setv(0, 24'h000120);
        bus.req = 4'b0001;
        cycle();
`ifdef LEADING_ZERO_BLANK_EN
        chk("t6_lz120", 32'(bus.blank), 32'b111000);
`else
        chk("t6_lz120", 32'(bus.blank), 32'b000000);
`endif
        setv(0, 24'h000000);
        cycle();
`ifdef LEADING_ZERO_BLANK_EN
        chk("t6_lz0", 32'(bus.blank), 32'b111110);
`else
        chk("t6_lz0", 32'(bus.blank), 32'b000000);
`endif

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) bus.req = N'($urandom);
            for (int r = 0; r < N; r++) begin
                if ($urandom_range(7) == 0) begin
                    case ($urandom_range(2))
                        0: setv(r, 24'($urandom));
                        1: setv(r, 24'($urandom) & 24'h0000FF);
                        default: setv(r, 24'h0);
                    endcase
                end
            end
            reset = ($urandom_range(149) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
